// File: rtl/reg_file_pkg.sv
// Shared defaults and word types for the scoreboarded register file.
package reg_file_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_NUM_REGS   = 32;
  localparam int unsigned DEF_NUM_RD     = 2;
  localparam int unsigned DEF_ADDR_W     = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_ADDR_W-1:0]     addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/sb_tracker.sv
// Busy-bit scoreboard: one pending-write bit per register, reservation
// acceptance and a registered count of outstanding reservations.
module sb_tracker
  import reg_file_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS),
  localparam int unsigned CNT_W   = $clog2(NUM_REGS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                rsv_en,
  input  logic [ADDR_W-1:0]   rsv_addr,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy,
  output logic                rsv_ack_c,
  output logic [CNT_W-1:0]    busy_cnt
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // A free, x0, or same-cycle-retiring destination can be reserved.
  assign rsv_ack_c = rsv_en && !flush && !rst &&
                     ((rsv_addr == '0) || !busy_q[rsv_addr] ||
                      (wr_en && (wr_addr == rsv_addr)));

  // Next busy vector: flush wins, then writeback clears, then reserve sets.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_en)     busy_d[wr_addr]  = 1'b0;
      if (rsv_ack_c) busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cnt_d = cnt_d + CNT_W'(busy_d[i]);
    end
  end

  // Scoreboard state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // x0 is never busy, so the count tops out at NUM_REGS-1 and cannot wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (cnt_d <= CNT_W'(NUM_REGS - 1));
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with hardwired-zero x0, write bypass to combinational reads
// and a per-register busy scoreboard for issue-time destination reservation.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
  parameter int unsigned NUM_RD     = DEF_NUM_RD,
  localparam int unsigned ADDR_W    = $clog2(NUM_REGS),
  localparam int unsigned CNT_W     = $clog2(NUM_REGS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_W-1:0]     rdAddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdData,
  output logic [NUM_RD-1:0]            rdBusy,
  input  logic                         wrEn,
  input  logic [ADDR_W-1:0]            wrAddr,
  input  logic [DATA_WIDTH-1:0]        wrData,
  input  logic                         rsvEn,
  input  logic [ADDR_W-1:0]            rsvAddr,
  output logic                         rsvAck,
  input  logic                         flush,
  output logic [CNT_W-1:0]             busyCnt
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;

  sb_tracker #(
    .NUM_REGS (NUM_REGS)
  ) u_sb_tracker (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wrEn),
    .wr_addr   (wrAddr),
    .rsv_en    (rsvEn),
    .rsv_addr  (rsvAddr),
    .flush     (flush),
    .busy      (busy),
    .rsv_ack_c (rsvAck),
    .busy_cnt  (busyCnt)
  );

  // Writeback commits regardless of busy state; x0 stays zero.
  always_comb begin
    regs_d = regs_q;
    if (wrEn) regs_d[wrAddr] = wrData;
    regs_d[0] = '0;
  end

  // Register storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: same-cycle writeback bypasses storage and masks busy.
  for (genvar g = 0; g < int'(NUM_RD); g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    assign ra  = rdAddr[g*ADDR_W +: ADDR_W];
    assign hit = wrEn && (wrAddr == ra) && (ra != '0);
    assign rdData[g*DATA_WIDTH +: DATA_WIDTH] =
      (ra == '0) ? '0 : (hit ? wrData : regs_q[ra]);
    assign rdBusy[g] = busy[ra] && !hit;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized + directed bench for reg_file_sb against an array-based model.
module tb_reg_file_sb;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int AW  = 5;
  localparam int CW  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic              rsv_ack;
  logic              flush;
  logic [CW-1:0]     busy_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];

  reg_file_sb dut (
    .clk     (clk),
    .rst     (rst),
    .rdAddr  (rd_addr),
    .rdData  (rd_data),
    .rdBusy  (rd_busy),
    .wrEn    (wr_en),
    .wrAddr  (wr_addr),
    .wrData  (wr_data),
    .rsvEn   (rsv_en),
    .rsvAddr (rsv_addr),
    .rsvAck  (rsv_ack),
    .flush   (flush),
    .busyCnt (busy_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit exp_ack();
    if (!rsv_en || flush || rst) return 1'b0;
    if (rsv_addr == 0) return 1'b1;
    if (!m_busy[rsv_addr]) return 1'b1;
    return wr_en && (wr_addr == rsv_addr);
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  // Advance the model by the rules applied at a rising edge.
  task automatic model_step();
    bit ack;
    ack = exp_ack();
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
      if (flush) begin
        for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
      end else begin
        if (wr_en) m_busy[wr_addr] = 1'b0;
        if (ack && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = '0; wr_data = '0;
    rsv_en = 0; rsv_addr = '0; flush = 0; rst = 0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  function automatic logic [31:0] rdd(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  // Every cycle: compare all outputs with what the model says they must be.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int p = 0; p < NRD; p++) begin
        int a;
        bit byp;
        logic [DW-1:0] ed;
        a   = int'(rd_addr[p*AW +: AW]);
        byp = wr_en && (int'(wr_addr) == a) && (a != 0);
        ed  = (a == 0) ? '0 : (byp ? wr_data : m_regs[a]);
        chk($sformatf("rdData[%0d] a=%0d", p, a), rd_data[p*DW +: DW], ed);
        chk($sformatf("rdBusy[%0d] a=%0d", p, a), 32'(rd_busy[p]),
            32'(m_busy[a] && !byp));
      end
      chk("rsvAck", 32'(rsv_ack), 32'(exp_ack()));
      chk("busyCnt", 32'(busy_cnt), 32'(exp_cnt()));
    end
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    rd_addr = '0;
    idle();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    chk_on = 1'b1;

    // Reset state on every address.
    for (int a = 0; a < NR; a++) begin
      set_rd(0, a); set_rd(1, NR - 1 - a);
      #3;
      chk("rst rd0", rdd(0), 32'h0);
      chk("rst rd1", rdd(1), 32'h0);
      chk("rst busy", 32'(rd_busy), 32'h0);
      chk("rst cnt", 32'(busy_cnt), 32'h0);
      cycle();
    end

    // Write with same-cycle bypass, then from storage; x0 ignores writes.
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; set_rd(0, 5);
    #3 chk("bypass x5", rdd(0), 32'hDEADBEEF);
    cycle(); idle();
    #3 chk("stored x5", rdd(0), 32'hDEADBEEF);
    wr_en = 1; wr_addr = 0; wr_data = 32'h1; set_rd(0, 0);
    #3 chk("x0 bypass", rdd(0), 32'h0);
    cycle(); idle();
    #3 chk("x0 stored", rdd(0), 32'h0);

    // Reservation and rejected re-reservation.
    rsv_en = 1; rsv_addr = 7;
    #3 chk("rsv7 ack", 32'(rsv_ack), 32'h1);
    cycle();
    set_rd(0, 7);
    #3 chk("rsv7 again ack", 32'(rsv_ack), 32'h0);
    chk("x7 busy", 32'(rd_busy[0]), 32'h1);
    chk("cnt1", 32'(busy_cnt), 32'h1);
    cycle(); idle();
    #3 chk("cnt still 1", 32'(busy_cnt), 32'h1);

    // Writeback and re-reserve of the same register in one cycle.
    wr_en = 1; wr_addr = 7; wr_data = 32'h55; rsv_en = 1; rsv_addr = 7;
    #3 chk("wb+rsv ack", 32'(rsv_ack), 32'h1);
    chk("wb+rsv data", rdd(0), 32'h55);
    cycle(); idle();
    #3 chk("x7 still busy", 32'(rd_busy[0]), 32'h1);
    chk("cnt after wb+rsv", 32'(busy_cnt), 32'h1);
    chk("x7 stored", rdd(0), 32'h55);

    // Flush beats reserve, write still commits.
    flush = 1;
    cycle(); idle();
    #3 chk("cnt after flush", 32'(busy_cnt), 32'h0);
    rsv_en = 1; rsv_addr = 3; cycle();
    rsv_addr = 4; cycle();
    rsv_addr = 9; cycle(); idle();
    #3 chk("cnt3", 32'(busy_cnt), 32'h3);
    flush = 1; rsv_en = 1; rsv_addr = 10; wr_en = 1; wr_addr = 4; wr_data = 32'h12;
    set_rd(0, 4); set_rd(1, 10);
    #3 chk("flush rsv ack", 32'(rsv_ack), 32'h0);
    cycle(); idle();
    #3 chk("flush cnt0", 32'(busy_cnt), 32'h0);
    chk("x4 after flush", rdd(0), 32'h12);
    chk("x10 not busy", 32'(rd_busy[1]), 32'h0);

    // Reset overrides write and reserve.
    rsv_en = 1; rsv_addr = 3; cycle(); idle();
    rst = 1; wr_en = 1; wr_addr = 3; wr_data = 32'hAAAA; rsv_en = 1; rsv_addr = 8;
    set_rd(0, 3);
    #3 chk("ack in rst", 32'(rsv_ack), 32'h0);
    cycle(); idle();
    #3 chk("x3 after rst", rdd(0), 32'h0);
    chk("x3 busy after rst", 32'(rd_busy[0]), 32'h0);
    chk("cnt after rst", 32'(busy_cnt), 32'h0);

    // Random traffic concentrated on few addresses to force collisions.
    for (int n = 0; n < 3000; n++) begin
      int lim;
      lim = ($urandom_range(0, 3) == 0) ? NR - 1 : 7;
      rst      = ($urandom_range(0, 99) < 2);
      flush    = ($urandom_range(0, 99) < 5);
      wr_en    = $urandom_range(0, 1) == 1;
      wr_addr  = AW'($urandom_range(0, lim));
      wr_data  = $urandom;
      rsv_en   = $urandom_range(0, 1) == 1;
      rsv_addr = AW'($urandom_range(0, lim));
      set_rd(0, $urandom_range(0, lim));
      set_rd(1, $urandom_range(0, lim));
      cycle();
    end
    idle();
    cycle();
    chk_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
